instr_fetch_resp: RTL and testbench

INSTR_FETCH_RESP -- requirements
Module: instr_fetch_resp

---
 rtl/instr_fetch_resp_pkg.sv | 18 +
 rtl/instr_fetch_resp_ibuf_line.sv | 34 +++
 rtl/instr_fetch_resp.sv | 122 ++++++++++++
 tb/tb_instr_fetch_resp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch line buffer: FSM encoding,
// the NOP filler word and the default line size.
package instr_fetch_resp_pkg;

  localparam int          DEFAULT_LINE_WORDS = 4;
  localparam logic [31:0] NOP_WORD           = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_FILL = 2'b10
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_resp_ibuf_line.sv
// Single-line instruction buffer: LINE_WORDS words written one beat at a time,
// read asynchronously by word index.
module ibuf_line
  import instr_fetch_resp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] words_q [LINE_WORDS];

  // Reset preloads NOPs so a stale read can never surface random data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= WIDTH'(NOP_WORD);
      end
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = words_q[rd_idx_i];

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction fetch responder: zero-latency hits out of a one-line buffer,
// line refill from backing memory via a request/ack then beat-stream handshake.
module instr_fetch_resp
  import instr_fetch_resp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_addr,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             stall_fetch,
  output logic             misalign,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = WIDTH - OFF_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  fetch_state_e     state_q;
  logic             line_valid_q;
  logic [IDX_W-1:0] beat_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] req_line_q;
  logic             mem_req_q;
  logic [WIDTH-1:0] mem_addr_q;

  logic [TAG_W-1:0] addr_tag_s;
  logic [IDX_W-1:0] word_idx_s;
  logic             misalign_s;
  logic             hit_s;
  logic             miss_start_s;
  logic             buf_wr_en_s;
  logic [WIDTH-1:0] buf_rd_data_s;

  assign addr_tag_s   = instr_addr[WIDTH-1:OFF_W];
  assign word_idx_s   = instr_addr[OFF_W-1:2];
  assign misalign_s   = is_misaligned(instr_addr[1:0]);
  assign hit_s        = (state_q == ST_IDLE) && line_valid_q
                        && (tag_q == addr_tag_s) && !misalign_s;
  assign miss_start_s = (state_q == ST_IDLE) && !misalign_s && !hit_s;
  assign buf_wr_en_s  = (state_q == ST_FILL) && mem_rvalid;

  ibuf_line #(
    .WIDTH      (WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_ibuf_line (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (buf_wr_en_s),
    .wr_idx_i  (beat_q),
    .wr_data_i (mem_rdata),
    .rd_idx_i  (word_idx_s),
    .rd_data_o (buf_rd_data_s)
  );

  // Refill FSM; mem_req/mem_addr are registered alongside the state so they
  // are exactly "in REQ" without a combinational path from instr_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      beat_q       <= '0;
      tag_q        <= '0;
      req_line_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_start_s) begin
            state_q      <= ST_REQ;
            line_valid_q <= 1'b0;
            req_line_q   <= addr_tag_s;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {addr_tag_s, {OFF_W{1'b0}}};
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q    <= ST_FILL;
            beat_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + IDX_W'(1);
            if (beat_q == LAST_BEAT) begin
              tag_q        <= req_line_q;
              line_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_req_q  <= 1'b0;
          mem_addr_q <= '0;
        end
      endcase
    end
  end

  // Hit path is purely combinational so the IF stage sees the word in-cycle.
  assign instr       = hit_s ? buf_rd_data_s : WIDTH'(NOP_WORD);
  assign instr_valid = hit_s;
  assign stall_fetch = (state_q != ST_IDLE) || miss_start_s;
  assign misalign    = misalign_s;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Directed and randomized bench for instr_fetch_resp; the bench plays the
// backing memory and tracks the expected line contents itself.
module tb_instr_fetch_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_fetch;
  logic        misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the buffered line should hold and whether it is usable.
  bit          m_valid;
  logic [27:0] m_tag;
  logic [31:0] m_words [4];

  instr_fetch_resp dut (
    .clk         (clk),
    .rst         (rst),
    .instr_addr  (instr_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall_fetch (stall_fetch),
    .misalign    (misalign),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit m_mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return !m_mis(a) && m_valid && (m_tag == a[31:4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a cycle in which the DUT is expected to be idle (no fill running).
  task automatic check_idle(input string tag);
    bit hit;
    @(negedge clk);
    hit = m_hit(instr_addr);
    chk({tag, ".valid"},    32'(instr_valid), 32'(hit));
    chk({tag, ".instr"},    instr, hit ? m_words[instr_addr[3:2]] : NOP);
    chk({tag, ".stall"},    32'(stall_fetch), 32'(!hit && !m_mis(instr_addr)));
    chk({tag, ".misalign"}, 32'(misalign), 32'(m_mis(instr_addr)));
    chk({tag, ".mem_req"},  32'(mem_req), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
  endtask

  // Serves one line fill; entered in the miss cycle after check_idle.
  task automatic fill(input logic [31:0] redirect, input int req_cycles,
                      input int gap [4], output int stall_cnt);
    logic [31:0] line;
    line      = {instr_addr[31:4], 4'h0};
    stall_cnt = 0;
    m_valid   = 1'b0;
    tick();
    for (int r = 0; r < req_cycles; r++) begin
      mem_ack    = (r == req_cycles - 1);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("req.mem_req",  32'(mem_req), 32'd1);
      chk("req.mem_addr", mem_addr, line);
      chk("req.stall",    32'(stall_fetch), 32'd1);
      chk("req.valid",    32'(instr_valid), 32'd0);
      chk("req.instr",    instr, NOP);
      stall_cnt = stall_cnt + int'(stall_fetch);
      tick();
    end
    mem_ack    = 1'b0;
    instr_addr = redirect;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap[b]; g++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        @(negedge clk);
        chk("gap.stall",    32'(stall_fetch), 32'd1);
        chk("gap.mem_req",  32'(mem_req), 32'd0);
        chk("gap.mem_addr", mem_addr, 32'd0);
        chk("gap.valid",    32'(instr_valid), 32'd0);
        stall_cnt = stall_cnt + int'(stall_fetch);
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      m_words[b] = mem_rdata;
      @(negedge clk);
      chk("beat.stall", 32'(stall_fetch), 32'd1);
      chk("beat.valid", 32'(instr_valid), 32'd0);
      stall_cnt = stall_cnt + int'(stall_fetch);
      tick();
    end
    mem_rvalid = 1'b0;
    m_valid    = 1'b1;
    m_tag      = line[31:4];
  endtask

  initial begin
    int n;
    int g [4];
    int line_i, word_i, lo_i;

    rst        = 1'b1;
    instr_addr = 32'h0000_0006;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    m_valid    = 1'b0;
    m_tag      = 28'd0;
    for (int i = 0; i < 4; i++) m_words[i] = NOP;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    tick();

    // Cold miss at 0x0: ack on second REQ cycle, four back-to-back beats.
    instr_addr = 32'h0000_0000;
    check_idle("cold");
    g = '{0, 0, 0, 0};
    fill(32'h0000_0000, 2, g, n);
    chk("cold.stall_cycles", 32'(1 + n), 32'd7);
    check_idle("cold.hit0");
    chk("cold.hit0_is_beat0", instr, m_words[0]);
    tick();

    // Hits on consecutive cycles within the same line.
    for (int a = 4; a <= 12; a += 4) begin
      instr_addr = 32'(a);
      check_idle("hit_seq");
      tick();
    end

    // Line change with a 3-cycle gap between beats 1 and 2.
    instr_addr = 32'h0000_0010;
    check_idle("line10");
    g = '{0, 0, 3, 0};
    fill(32'h0000_0010, 1, g, n);
    check_idle("line10.hit");
    chk("line10.valid", 32'(instr_valid), 32'd1);
    tick();

    // Misaligned fetch: no stall, no request.
    instr_addr = 32'h0000_0006;
    check_idle("misalign");
    tick();

    // Reset after beat 1 of a fill, then stray beats that must be ignored.
    instr_addr = 32'h0000_0000;
    check_idle("midrst.miss");
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_0000;
    tick();
    mem_rdata = 32'hDEAD_0001;
    tick();
    rst       = 1'b1;
    mem_rdata = 32'hDEAD_0002;
    tick();
    rst        = 1'b0;
    m_valid    = 1'b0;
    instr_addr = 32'h0000_0006;
    mem_rdata  = 32'hDEAD_0003;
    check_idle("midrst.after");
    tick();
    check_idle("midrst.stray");
    tick();
    mem_rvalid = 1'b0;
    instr_addr = 32'h0000_0000;
    check_idle("midrst.refetch");
    g = '{1, 0, 0, 2};
    fill(32'h0000_0000, 1, g, n);
    check_idle("midrst.hit");
    chk("midrst.valid", 32'(instr_valid), 32'd1);
    tick();

    // Redirect 0x20 -> 0x40 during FILL: next fill starts without an idle gap.
    instr_addr = 32'h0000_0020;
    check_idle("redir.miss");
    g = '{0, 1, 0, 0};
    fill(32'h0000_0040, 1, g, n);
    chk("redir.tag20", 32'(m_tag), 32'h2);
    check_idle("redir.restart");
    fill(32'h0000_0044, 1, g, n);
    check_idle("redir.hit44");
    chk("redir.valid", 32'(instr_valid), 32'd1);
    tick();

    // Random fetch stream with random memory timing and stray beats.
    for (int it = 0; it < 80; it++) begin
      line_i     = int'($urandom_range(0, 5));
      word_i     = int'($urandom_range(0, 3));
      lo_i       = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      instr_addr = 32'((line_i << 4) | (word_i << 2) | lo_i);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      check_idle("rand");
      if (!m_hit(instr_addr) && !m_mis(instr_addr)) begin
        for (int b = 0; b < 4; b++) g[b] = int'($urandom_range(0, 2));
        fill(32'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2)),
             int'($urandom_range(1, 3)), g, n);
      end else begin
        tick();
      end
    end
    mem_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
